// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage-register enables/flushes out.
// master = pipeline datapath side, slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_bubble;
  logic             mem_err;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_en, memwb_bubble, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_en, memwb_bubble, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush, dmem freeze, timeout.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int IMEM_LAT = 1,
  parameter int MEM_TMO  = 255,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  pipe_hazard_ctrl_if.slave    hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]     perf_stall_cnt,
  output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);
  localparam int WT_W = $clog2(MEM_TMO + 1);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [WT_W-1:0]   wait_q, wait_d;
  logic              mem_err_q, mem_err_d;

  logic [REG_W-1:0]  id_rs1, id_rs2, ex_rd;
  logic              stall_req, load_use;
  logic              pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic              exmem_en, memwb_en, memwb_bubble;

  assign id_rs1    = hz.id_rs1;
  assign id_rs2    = hz.id_rs2;
  assign ex_rd     = hz.ex_rd;
  assign stall_req = hz.dmem_req & ~hz.dmem_ready;
  assign load_use  = hz.ex_memread && (ex_rd != '0) &&
                     ((hz.id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (hz.id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        // After a timeout the pipe stays frozen until reset, even if ready shows up.
        if (mem_err_q || !hz.dmem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_bubble = 1'b1;
          if (wait_q != '1) wait_d = wait_q + 1'b1;
        end else begin
          wait_d  = '0;
          state_d = (flush_cnt_q != 3'd0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (stall_req) begin
          // The stall cycle still consumes one fetch-latency slot; the rest survives the freeze.
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_bubble = 1'b1;
          if (flush_cnt_q != 3'd0) flush_cnt_d = flush_cnt_q - 3'd1;
          wait_d  = WT_W'(1);
          state_d = MEM_WAIT;
        end else begin
          ifid_flush = 1'b1;
          if (flush_cnt_q != 3'd0) flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) state_d = RUN;
        end
      end
      default: begin
        if (stall_req) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_bubble = 1'b1;
          wait_d  = WT_W'(1);
          state_d = MEM_WAIT;
        end else if (hz.ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_cnt_d = 3'(IMEM_LAT);
          state_d     = (IMEM_LAT > 0) ? FLUSH : RUN;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
    endcase

    if (wait_d >= WT_W'(MEM_TMO)) mem_err_d = 1'b1;

    if (!rstn) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_bubble, memwb_bubble}       = 3'b000;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!pc_en && perf_stall_q != '1)     perf_stall_d = perf_stall_q + 1'b1;
    if (ifid_flush && perf_flush_q != '1) perf_flush_d = perf_flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mem_err      = mem_err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios, then randomized traffic,
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int LAT = 2;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(5)) bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.REG_W(5), .IMEM_LAT(LAT), .MEM_TMO(TMO), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit verbose = 1'b1;

  // Expected {pc_en,ifid_en,ifid_flush,idex_en,idex_bubble,exmem_en,memwb_en,memwb_bubble,mem_err}
  logic [8:0]  exp_q[$];
  longint      exp_ps_q[$];
  longint      exp_pf_q[$];

  // Model state: mode 0=normal, 1=flushing wrong-path fetches, 2=frozen on dmem
  int     m_mode = 0;
  int     m_flush_left = 0;
  int     m_waited = 0;
  bit     m_err = 1'b0;
  longint m_ps = 0;
  longint m_pf = 0;

  task automatic st(input bit rn, input bit [4:0] rs1, input bit [4:0] rs2,
                    input bit u1, input bit u2, input bit [4:0] rd, input bit mr,
                    input bit redir, input bit req, input bit rdy);
    bit pe, ie, ifl, de, db, xe, we, wb;
    bit frozen, lu;
    int n_mode, n_flush, n_wait;
    bit n_err;
    rstn = rn;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.ex_rd = rd; bus.ex_memread = mr; bus.ex_redirect = redir;
    bus.dmem_req = req; bus.dmem_ready = rdy;

    {pe, ie, ifl, de, db, xe, we, wb} = 8'b1101_0110;
    n_mode = m_mode; n_flush = m_flush_left; n_wait = m_waited; n_err = m_err;
    frozen = 1'b0;
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

    if (m_mode == 2) begin
      if (m_err || !rdy) begin
        frozen = 1'b1;
        n_wait = m_waited + 1;
      end else begin
        n_wait = 0;
        n_mode = (m_flush_left > 0) ? 1 : 0;
      end
    end else if (req && !rdy) begin
      frozen = 1'b1;
      if (m_mode == 1) n_flush = m_flush_left - 1;
      n_mode = 2;
      n_wait = 1;
    end else if (m_mode == 1) begin
      ifl = 1'b1;
      n_flush = m_flush_left - 1;
      if (n_flush == 0) n_mode = 0;
    end else if (redir) begin
      ifl = 1'b1; db = 1'b1;
      n_flush = LAT;
      n_mode = (LAT > 0) ? 1 : 0;
    end else if (lu) begin
      pe = 1'b0; ie = 1'b0; db = 1'b1;
    end
    if (frozen) begin
      {pe, ie, de, xe} = 4'b0000;
      wb = 1'b1;
    end
    if (n_wait >= TMO) n_err = 1'b1;

    if (!rn) begin
      {pe, ie, ifl, de, db, xe, we, wb} = 8'b0;
      n_mode = 0; n_flush = 0; n_wait = 0; n_err = 1'b0;
    end

    exp_q.push_back({pe, ie, ifl, de, db, xe, we, wb, m_err});
    exp_ps_q.push_back(m_ps);
    exp_pf_q.push_back(m_pf);

    @(posedge clk);
    #1;
    if (!rn) begin
      m_ps = 0; m_pf = 0;
    end else begin
      if (!pe) m_ps++;
      if (ifl) m_pf++;
    end
    m_mode = n_mode; m_flush_left = n_flush; m_waited = n_wait; m_err = n_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  always @(negedge clk) begin
    logic [8:0] e, a;
    longint eps, epf;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      eps = exp_ps_q.pop_front();
      epf = exp_pf_q.pop_front();
      a = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble,
           bus.exmem_en, bus.memwb_en, bus.memwb_bubble, bus.mem_err};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d got=%b expected=%b", cyc, a, e);
      end else if (verbose) begin
        $display("[TB] cyc %0d rstn=%b redir=%b req=%b rdy=%b out=%b", cyc, rstn,
                 bus.ex_redirect, bus.dmem_req, bus.dmem_ready, a);
      end
`ifdef PIPE_HAZARD_PERF_EN
      tests++;
      if (longint'(perf_stall_cnt) != eps || longint'(perf_flush_cnt) != epf) begin
        fails++;
        $display("FAIL perf cyc=%0d got=%0d/%0d expected=%0d/%0d", cyc,
                 perf_stall_cnt, perf_flush_cnt, eps, epf);
      end
`else
      if (eps < 0 || epf < 0) $display("[TB] perf model out of range");
`endif
    end
  end

  initial begin
    int budget;
    rstn = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rd = '0; bus.ex_memread = 1'b0; bus.ex_redirect = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // reset state: everything low
    idle(1);
    st(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);          // load-use on rs1
    idle(1);
    st(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);          // x0 destination: no stall
    st(1, 3, 7, 1, 0, 7, 1, 0, 0, 0);          // rs2 match but unused: no stall
    st(1, 9, 7, 0, 1, 7, 1, 0, 0, 0);          // load-use on rs2
    st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);          // redirect
    idle(3);
    repeat (3) st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);          // release
    idle(1);
    st(1, 5, 0, 1, 0, 5, 1, 1, 1, 0);          // stall + redirect + load-use
    st(1, 5, 0, 1, 0, 5, 1, 1, 1, 1);          // release ignores the others
    st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);          // redirect re-presented
    st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);          // stall during flush
    st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);          // release
    idle(3);
    repeat (6) st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); // timeout
    repeat (2) st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); // stays frozen after error
    st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);          // reset mid-wait
    idle(2);

    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st(($urandom_range(0, 99) >= 2),
         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
         ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
         ($urandom_range(0, 99) < 60));
    end

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
